// File: rtl/pause_dim_ctrl.sv
// Pause arbitration and screen-dim stage in front of the arcade video scaler.
// Debounced user pause toggle, merged halt request, and timed RGB dimming.
module pause_dim_ctrl #(
  parameter int DIM_DELAY = 480000000,
  parameter int TIMER_W   = 32,
  parameter int DEBOUNCE  = 16,
  parameter int DB_W      = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause_btn,
  input  logic        osd_open,
  input  logic        osd_pause_en,
  input  logic        hs_access,
  input  logic        ce_pix,
  input  logic [11:0] rgb_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        hbl_in,
  input  logic        vbl_in,
  output logic        pause,
  output logic        user_paused,
  output logic        dim,
  output logic [11:0] rgb_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        hbl_out,
  output logic        vbl_out
);

  localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [TIMER_W-1:0] DIM_LAST = TIMER_W'(DIM_DELAY - 1);

  typedef enum logic [1:0] {RUN, PAUSED, DIMMED} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               btn_meta, btn_sync, btn_stable;
  logic [DB_W-1:0]    db_cnt;
  logic               press;
  logic               user_paused_next;
  logic               ce_pix_unused;

  // The video path registers every clock; pixel enable is deliberately ignored.
  assign ce_pix_unused = ce_pix;

  // Press fires in the same cycle the stable level flips from 0 to 1.
  assign press = btn_sync & ~btn_stable & (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= '0;
    end else begin
      btn_meta <= pause_btn;
      btn_sync <= btn_meta;
      if (btn_sync != btn_stable) begin
        if (db_cnt == DB_LAST) begin
          btn_stable <= btn_sync;
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      RUN: begin
        if (press) begin
          state_next = PAUSED;
          timer_next = '0;
        end
      end
      PAUSED: begin
        // A press on the threshold cycle takes priority over dimming.
        if (press) begin
          state_next = RUN;
          timer_next = '0;
        end else begin
          timer_next = timer + TIMER_W'(1);
          if (timer == DIM_LAST) state_next = DIMMED;
        end
      end
      DIMMED: begin
        if (press) begin
          state_next = RUN;
          timer_next = '0;
        end
      end
      default: begin
        state_next = RUN;
        timer_next = '0;
      end
    endcase
  end

  assign user_paused_next = (state_next != RUN);
  assign user_paused      = (state != RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      timer <= '0;
      dim   <= 1'b0;
      pause <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      dim   <= (state_next == DIMMED);
      pause <= user_paused_next | hs_access | (osd_open & osd_pause_en);
    end
  end

  // Dimming halves each 4-bit channel; sync and blank pass through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out <= '0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      hbl_out <= 1'b0;
      vbl_out <= 1'b0;
    end else begin
      rgb_out <= dim ? {1'b0, rgb_in[11:9], 1'b0, rgb_in[7:5], 1'b0, rgb_in[3:1]} : rgb_in;
      hs_out  <= hs_in;
      vs_out  <= vs_in;
      hbl_out <= hbl_in;
      vbl_out <= vbl_in;
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl with DEBOUNCE = 4 and DIM_DELAY = 20.
// Video results go through a scoreboard queue; control outputs are checked directly.
module tb_pause_dim_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause_btn, osd_open, osd_pause_en, hs_access, ce_pix;
  logic [11:0] rgb_in;
  logic        hs_in, vs_in, hbl_in, vbl_in;
  logic        pause, user_paused, dim;
  logic [11:0] rgb_out;
  logic        hs_out, vs_out, hbl_out, vbl_out;

  typedef struct packed {
    logic [11:0] rgb;
    logic [3:0]  syncs;
  } pix_t;

  pix_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic exp_dim    = 1'b0;

  pause_dim_ctrl #(
    .DIM_DELAY(20),
    .TIMER_W  (32),
    .DEBOUNCE (4),
    .DB_W     (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pause_btn   (pause_btn),
    .osd_open    (osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_access   (hs_access),
    .ce_pix      (ce_pix),
    .rgb_in      (rgb_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .hbl_in      (hbl_in),
    .vbl_in      (vbl_in),
    .pause       (pause),
    .user_paused (user_paused),
    .dim         (dim),
    .rgb_out     (rgb_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .hbl_out     (hbl_out),
    .vbl_out     (vbl_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] halve(input logic [11:0] c);
    logic [3:0] r, g, b;
    r = c[11:8] / 4'd2;
    g = c[7:4]  / 4'd2;
    b = c[3:0]  / 4'd2;
    return {r, g, b};
  endfunction

  // Drive one pixel and record what should appear one clock later.
  task automatic applyStimulus(input logic [11:0] rgb, input logic [3:0] syncs);
    pix_t e;
    rgb_in = rgb;
    {hs_in, vs_in, hbl_in, vbl_in} = syncs;
    ce_pix = 1'($urandom_range(0, 1));
    e.rgb   = exp_dim ? halve(rgb) : rgb;
    e.syncs = syncs;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    pix_t e;
    tick();
    chk("sb_not_empty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
      chk("sync_blank", 32'({hs_out, vs_out, hbl_out, vbl_out}), 32'(e.syncs));
    end
  endtask

  task automatic doPress();
    pause_btn = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    reset_n = 1'b0; pause_btn = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0;
    hs_access = 1'b0; ce_pix = 1'b0;
    rgb_in = 12'hABC; hs_in = 1'b1; vs_in = 1'b1; hbl_in = 1'b1; vbl_in = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst_rgb_out", 32'(rgb_out), 32'h0);
    chk("rst_syncs", 32'({hs_out, vs_out, hbl_out, vbl_out}), 32'h0);
    chk("rst_pause", 32'(pause), 32'h0);
    chk("rst_user_paused", 32'(user_paused), 32'h0);
    chk("rst_dim", 32'(dim), 32'h0);
    reset_n = 1'b1;
    applyStimulus(12'hABC, 4'b1111);
    checkOutput();
    chk("post_rst_pause", 32'(pause), 32'h0);

    // Debounce: short bounce ignored, then held press toggles after 6 cycles
    pause_btn = 1'b1;
    repeat (3) tick();
    pause_btn = 1'b0;
    repeat (8) tick();
    chk("bounce_ignored", 32'(user_paused), 32'h0);
    pause_btn = 1'b1;
    repeat (5) tick();
    chk("press_lat5_user_paused", 32'(user_paused), 32'h0);
    chk("press_lat5_pause", 32'(pause), 32'h0);
    tick();
    chk("press_lat6_user_paused", 32'(user_paused), 32'h1);
    chk("press_lat6_pause", 32'(pause), 32'h1);
    repeat (4) tick();
    pause_btn = 1'b0;
    repeat (8) tick();
    chk("release_no_toggle", 32'(user_paused), 32'h1);
    doPress();
    chk("unpause_user_paused", 32'(user_paused), 32'h0);
    chk("unpause_pause", 32'(pause), 32'h0);
    chk("unpause_no_dim", 32'(dim), 32'h0);
    pause_btn = 1'b0;
    repeat (8) tick();

    // Dim timing and video halving
    doPress();
    chk("dim_enter_paused", 32'(user_paused), 32'h1);
    pause_btn = 1'b0;
    repeat (19) tick();
    chk("dim_at_19", 32'(dim), 32'h0);
    tick();
    chk("dim_at_20", 32'(dim), 32'h1);
    exp_dim = 1'b1;
    applyStimulus(12'hF81, 4'b1010);
    checkOutput();
    applyStimulus(12'hF81, 4'b0101);
    checkOutput();
    applyStimulus(12'h8A3, 4'b0011);
    checkOutput();
    repeat (10) tick();
    chk("dim_holds", 32'(dim), 32'h1);
    chk("dim_pause_held", 32'(pause), 32'h1);
    doPress();
    chk("undim_dim", 32'(dim), 32'h0);
    chk("undim_user_paused", 32'(user_paused), 32'h0);
    exp_dim = 1'b0;
    applyStimulus(12'hF81, 4'b1000);
    checkOutput();
    pause_btn = 1'b0;
    repeat (8) tick();

    // Independent pause sources
    osd_open = 1'b1;
    tick();
    chk("osd_no_en_pause", 32'(pause), 32'h0);
    osd_pause_en = 1'b1;
    tick();
    chk("osd_en_pause", 32'(pause), 32'h1);
    chk("osd_en_user_paused", 32'(user_paused), 32'h0);
    repeat (100) tick();
    chk("osd_long_dim", 32'(dim), 32'h0);
    chk("osd_long_user_paused", 32'(user_paused), 32'h0);
    osd_open = 1'b0;
    osd_pause_en = 1'b0;
    tick();
    chk("osd_clear_pause", 32'(pause), 32'h0);
    hs_access = 1'b1;
    tick();
    chk("hs_pulse_hi", 32'(pause), 32'h1);
    hs_access = 1'b0;
    tick();
    chk("hs_pulse_lo", 32'(pause), 32'h0);

    // Collision: press lands on the threshold cycle
    doPress();
    chk("coll_paused", 32'(user_paused), 32'h1);
    pause_btn = 1'b0;
    repeat (14) tick();
    pause_btn = 1'b1;
    repeat (5) tick();
    chk("coll_before_paused", 32'(user_paused), 32'h1);
    chk("coll_before_dim", 32'(dim), 32'h0);
    tick();
    chk("coll_user_paused", 32'(user_paused), 32'h0);
    chk("coll_dim", 32'(dim), 32'h0);
    pause_btn = 1'b0;
    repeat (30) tick();
    chk("coll_later_dim", 32'(dim), 32'h0);
    chk("coll_later_paused", 32'(user_paused), 32'h0);

    // Asynchronous reset while dimmed
    doPress();
    pause_btn = 1'b0;
    repeat (20) tick();
    chk("pre_rst_dim", 32'(dim), 32'h1);
    exp_dim = 1'b1;
    applyStimulus(12'hFFF, 4'b1111);
    checkOutput();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_dim", 32'(dim), 32'h0);
    chk("async_rst_pause", 32'(pause), 32'h0);
    chk("async_rst_rgb", 32'(rgb_out), 32'h0);
    chk("async_rst_user_paused", 32'(user_paused), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_dim = 1'b0;
    repeat (30) tick();
    chk("after_rst_user_paused", 32'(user_paused), 32'h0);
    chk("after_rst_dim", 32'(dim), 32'h0);
    chk("after_rst_pause", 32'(pause), 32'h0);
    applyStimulus(12'h5E9, 4'b0110);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
